// File: rtl/apb_wait_slave.sv
// apb_wait_slave: APB completer with a DEPTH-word register file, per-transfer wait states and SLVERR on bad addresses.
// Optional macro APB_WAIT_SLAVE_RAND_WAIT_EN: LFSR-driven wait count, capped at WAIT_CYCLES.
module apb_wait_slave #(
    parameter int          DEPTH       = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        Pclk,
    input  logic        Preset,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr
);
    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);
    localparam logic [3:0]  WMAX = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            wr_q;
    logic            legal_q;
    logic [31:0]     data_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     mem [DEPTH];

    logic [31:0]     off;
    logic            setup_legal;
    logic [AW-1:0]   setup_idx;
    logic [3:0]      wait_cnt;

    // Decode is done on the live bus at setup; the result is latched so
    // later bus changes during ACCESS cannot affect the transfer.
    always_comb begin
        off         = Paddr - BASE_ADDR;
        setup_legal = (off < SPAN) && (Paddr[1:0] == 2'b00);
        setup_idx   = off[AW+1:2];
    end

`ifdef APB_WAIT_SLAVE_RAND_WAIT_EN
    logic [7:0] lfsr;

    always_ff @(posedge Pclk) begin
        if (Preset)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign wait_cnt = (lfsr[3:0] < WMAX) ? lfsr[3:0] : WMAX;
`else
    assign wait_cnt = WMAX;
`endif

    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            Pready  <= 1'b0;
            Prdata  <= 32'd0;
            Pslverr <= 1'b0;
            wr_q    <= 1'b0;
            legal_q <= 1'b0;
            data_q  <= 32'd0;
            idx_q   <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (Psel && !Penable) begin
                        wr_q    <= Pwrite;
                        data_q  <= Pdata;
                        idx_q   <= setup_idx;
                        legal_q <= setup_legal;
                        cnt     <= wait_cnt;
                        Pready  <= (wait_cnt == 4'd0);
                        // Zero-wait transfers present their response straight away.
                        if (wait_cnt == 4'd0) begin
                            Pslverr <= !setup_legal;
                            if (!setup_legal)
                                Prdata <= 32'd0;
                            else if (!Pwrite)
                                Prdata <= mem[setup_idx];
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!Psel) begin
                        state   <= IDLE;
                        cnt     <= 4'd0;
                        Pready  <= 1'b0;
                        Pslverr <= 1'b0;
                    end else if (!Pready) begin
                        if (cnt != 4'd0)
                            cnt <= cnt - 4'd1;
                        Pready <= (cnt == 4'd1);
                        if (cnt == 4'd1) begin
                            Pslverr <= !legal_q;
                            if (!legal_q)
                                Prdata <= 32'd0;
                            else if (!wr_q)
                                Prdata <= mem[idx_q];
                        end
                    end else if (Penable) begin
                        if (wr_q && legal_q)
                            mem[idx_q] <= data_q;
                        state   <= IDLE;
                        cnt     <= 4'd0;
                        Pready  <= 1'b0;
                        Pslverr <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_wait_slave.sv
// Self-checking bench for apb_wait_slave: two instances (2 and 0 wait states) checked against a word-array model.
module tb_apb_wait_slave;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE0 = 32'h4000_1000;
    localparam logic [31:0] BASE1 = 32'h0000_0000;
    localparam int          W0    = 2;
    localparam int          W1    = 0;
    localparam logic [7:0]  SEED  = 8'hA5;

    logic        Pclk = 1'b0;
    logic        Preset;
    logic        psel [2];
    logic        penable [2];
    logic        pwrite [2];
    logic [31:0] paddr [2];
    logic [31:0] pdata [2];
    logic [31:0] prdata [2];
    logic        pready [2];
    logic        pslverr [2];

    logic [31:0] m_mem [2][DEPTH];
    logic [31:0] m_rd [2];
    logic [7:0]  m_lfsr;
    int          errors = 0;
    int          checks = 0;

    always #5 Pclk = ~Pclk;

    apb_wait_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE0), .WAIT_CYCLES(W0), .LFSR_SEED(SEED)) u_dut0 (
        .Pclk(Pclk), .Preset(Preset), .Psel(psel[0]), .Penable(penable[0]), .Pwrite(pwrite[0]),
        .Paddr(paddr[0]), .Pdata(pdata[0]), .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0]));

    apb_wait_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE1), .WAIT_CYCLES(W1), .LFSR_SEED(SEED)) u_dut1 (
        .Pclk(Pclk), .Preset(Preset), .Psel(psel[1]), .Penable(penable[1]), .Pwrite(pwrite[1]),
        .Paddr(paddr[1]), .Pdata(pdata[1]), .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1]));

    // Reference wait-state generator: 8-bit Fibonacci LFSR, taps 8,6,5,4.
    always @(posedge Pclk) begin
        if (Preset) m_lfsr <= SEED;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int exp_wait(input int i);
        int w;
        w = (i == 0) ? W0 : W1;
`ifdef APB_WAIT_SLAVE_RAND_WAIT_EN
        if (int'(m_lfsr[3:0]) < w) w = int'(m_lfsr[3:0]);
`endif
        return w;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            m_rd[i] = 32'd0;
            for (int k = 0; k < DEPTH; k++) m_mem[i][k] = 32'd0;
        end
    endtask

    // One full APB transfer; bus is scrambled during ACCESS to show only setup values matter.
    task automatic xfer(input int i, input bit wr, input logic [31:0] addr, input logic [31:0] data, input string tag);
        int          n;
        int          ew;
        int          idx;
        bit          legal;
        logic [31:0] off;
        logic [31:0] exp_rd;
        @(negedge Pclk);
        psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = wr; paddr[i] = addr; pdata[i] = data;
        ew = exp_wait(i);
        @(negedge Pclk);
        penable[i] = 1'b1;
        paddr[i] = $urandom;
        pdata[i] = $urandom;
        n = 0;
        while (pready[i] !== 1'b1 && n < 40) begin
            @(negedge Pclk);
            n++;
        end
        chk({tag, ".wait"}, 32'(n), 32'(ew));
        off   = addr - ((i == 0) ? BASE0 : BASE1);
        legal = (off < 32'(DEPTH * 4)) && (addr[1:0] == 2'b00);
        idx   = legal ? int'(off >> 2) : 0;
        exp_rd = !legal ? 32'd0 : (wr ? m_rd[i] : m_mem[i][idx]);
        chk({tag, ".slverr"}, 32'(pslverr[i]), 32'(!legal));
        chk({tag, ".rdata"}, prdata[i], exp_rd);
        m_rd[i] = exp_rd;
        if (legal && wr) m_mem[i][idx] = data;
        @(posedge Pclk);
        #1;
        psel[i] = 1'b0; penable[i] = 1'b0;
        chk({tag, ".ready_drop"}, 32'(pready[i]), 32'd0);
    endtask

    initial begin
        bit          seen;
        int          r;
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = 32'd0; pdata[i] = 32'd0;
        end
        Preset = 1'b1;
        repeat (3) @(negedge Pclk);
        clear_model();
        for (int i = 0; i < 2; i++) begin
            chk("reset.pready", 32'(pready[i]), 32'd0);
            chk("reset.prdata", prdata[i], 32'd0);
            chk("reset.pslverr", 32'(pslverr[i]), 32'd0);
        end
        Preset = 1'b0;

        // First read, write/readback, illegal addresses
        xfer(0, 1'b0, BASE0 + 32'h0C, 32'd0, "rd_w3");
        xfer(0, 1'b1, BASE0 + 32'h08, 32'hDEAD_BEEF, "wr_w2");
        xfer(0, 1'b0, BASE0 + 32'h08, 32'd0, "rd_w2");
        xfer(0, 1'b1, BASE0 + 32'h40, 32'h1111_1111, "wr_oob");
        xfer(0, 1'b1, BASE0 + 32'h02, 32'h2222_2222, "wr_misal");
        xfer(0, 1'b0, BASE0 - 32'h04, 32'd0, "rd_below");
        xfer(0, 1'b0, BASE0 + 32'h00, 32'd0, "rd_w0_after_err");
        xfer(0, 1'b0, BASE0 + 32'h08, 32'd0, "rd_w2_after_err");
        xfer(0, 1'b0, BASE0 + 32'h3C, 32'd0, "rd_last");

        // Access strobe with no setup phase must be ignored
        @(negedge Pclk);
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = BASE0; pdata[0] = 32'hFFFF_FFFF;
        seen = 1'b0;
        repeat (4) begin
            @(negedge Pclk);
            if (pready[0] === 1'b1) seen = 1'b1;
        end
        psel[0] = 1'b0; penable[0] = 1'b0;
        chk("no_setup.pready", 32'(seen), 32'd0);
        xfer(0, 1'b0, BASE0, 32'd0, "no_setup.rd_w0");

        // Abort: Psel dropped in the first access cycle
        xfer(0, 1'b1, BASE0 + 32'h14, 32'h0000_0055, "wr_w5");
        @(negedge Pclk);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = BASE0 + 32'h14; pdata[0] = 32'hBAD0_0005;
        @(negedge Pclk);
        psel[0] = 1'b0; penable[0] = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge Pclk);
            if (pready[0] !== 1'b0) seen = 1'b1;
        end
        chk("abort.pready", 32'(seen), 32'd0);
        xfer(0, 1'b0, BASE0 + 32'h14, 32'd0, "abort.rd_w5");

        // Zero-wait instance: back-to-back writes then reads
        for (int k = 0; k < 4; k++)
            xfer(1, 1'b1, BASE1 + 32'(k * 4), 32'hA000_0000 + 32'(k), "zw.wr");
        for (int k = 0; k < 4; k++)
            xfer(1, 1'b0, BASE1 + 32'(k * 4), 32'd0, "zw.rd");

        // Reset in the middle of a pending write to word 1
        @(negedge Pclk);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = BASE0 + 32'h04; pdata[0] = 32'h1234_5678;
        @(negedge Pclk);
        penable[0] = 1'b1;
        @(negedge Pclk);
        Preset = 1'b1;
        @(posedge Pclk);
        #1;
        chk("midrst.pready", 32'(pready[0]), 32'd0);
        chk("midrst.prdata0", prdata[0], 32'd0);
        chk("midrst.prdata1", prdata[1], 32'd0);
        chk("midrst.pslverr", 32'(pslverr[0]), 32'd0);
        @(negedge Pclk);
        Preset = 1'b0;
        psel[0] = 1'b0; penable[0] = 1'b0;
        clear_model();
        xfer(0, 1'b0, BASE0 + 32'h04, 32'd0, "midrst.rd_w1");
        xfer(1, 1'b0, BASE1 + 32'h04, 32'd0, "midrst.rd1_w1");

        // Random traffic, occasional out-of-range and misaligned addresses
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, DEPTH + 3);
            a = BASE0 + 32'(r * 4);
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
            xfer(0, 1'($urandom_range(0, 1)), a, $urandom, "rnd0");
        end
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, DEPTH + 3);
            a = BASE1 + 32'(r * 4);
            xfer(1, 1'($urandom_range(0, 1)), a, $urandom, "rnd1");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
